// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings, sequencer state encoding, command
//                record layout and default FIFO depth for alu_cmd_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings carried on in_select
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHR = 3'b110,
        OP_SHL = 3'b111
    } alu_op_e;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Default number of command FIFO entries
    localparam int c_FIFO_DEPTH_DEFAULT = 4;

    // One queued command
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } alu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_4b.sv
`default_nettype none
// ============================================================================
//  Module      : alu_4b
//  Description : Purely combinational 4-bit ALU datapath (result only; the
//                sequencer derives carry/borrow/shift-out flags itself).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_4b
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] select,
    output logic [3:0] result
);

    // Opcode decode to a 4-bit modulo result
    always_comb begin
        result = 4'd0;
        case (alu_op_e'(select))
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHR:  result = {1'b0, a[3:1]};
            OP_SHL:  result = {a[2:0], 1'b0};
            default: result = 4'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_seq
//  Description : Command FIFO feeding a 3-state sequencer (IDLE/EXEC/DONE)
//                around a 4-bit ALU, with a valid/ready result register and
//                a consumed-result counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [2:0] in_select,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_flag,
    output logic       out_zero,
    output logic [7:0] op_count
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

    // FIFO storage and bookkeeping
    alu_cmd_t             fifo_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;

    // Sequencer state, operand and output registers
    seq_state_e           state_q, state_d;
    logic [3:0]           a_q, b_q;
    logic [2:0]           sel_q;
    logic [3:0]           result_q;
    logic                 flag_q;
    logic                 zero_q;
    logic                 valid_q;
    logic [7:0]           op_count_q;

    // Combinational control and datapath
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_capture;
    logic                 w_consume;
    logic [3:0]           w_result;
    logic                 w_flag;
    logic [4:0]           w_sum;
    alu_cmd_t             w_in_cmd;
    alu_cmd_t             w_head;

    assign w_full   = (count_q == c_FULL_CNT);
    assign w_empty  = (count_q == '0);
    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;
    assign w_in_cmd = '{a: in_a, b: in_b, sel: in_select};
    assign w_head   = fifo_q[rd_ptr_q];

    // FIFO entry write; pointers are reset elsewhere so contents need no reset
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            fifo_q[wr_ptr_q] <= w_in_cmd;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_W'(1);
                2'b01:   count_q <= count_q - c_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and control strobes
    always_comb begin
        state_d   = state_q;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_consume = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                w_capture = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_consume = 1'b1;
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers load from the FIFO head on every pop
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= 4'd0;
            b_q   <= 4'd0;
            sel_q <= 3'd0;
        end else if (w_pop) begin
            a_q   <= w_head.a;
            b_q   <= w_head.b;
            sel_q <= w_head.sel;
        end
    end

    alu_4b u_alu (
        .a      (a_q),
        .b      (b_q),
        .select (sel_q),
        .result (w_result)
    );

    assign w_sum = {1'b0, a_q} + {1'b0, b_q};

    // Flag: carry for add, borrow for sub, shifted-out bit for shifts
    always_comb begin
        w_flag = 1'b0;
        case (alu_op_e'(sel_q))
            OP_ADD:  w_flag = w_sum[4];
            OP_SUB:  w_flag = (a_q < b_q);
            OP_SHR:  w_flag = a_q[0];
            OP_SHL:  w_flag = a_q[3];
            default: w_flag = 1'b0;
        endcase
    end

    // Result register: captured in EXEC, held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 4'd0;
            flag_q   <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (w_capture) begin
            result_q <= w_result;
            flag_q   <= w_flag;
            zero_q   <= (w_result == 4'd0);
            valid_q  <= 1'b1;
        end else if (w_consume) begin
            valid_q  <= 1'b0;
        end
    end

    // Consumed-result counter, wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= 8'd0;
        end else if (w_consume) begin
            op_count_q <= op_count_q + 8'd1;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_flag   = flag_q;
    assign out_zero   = zero_q;
    assign op_count   = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_seq
//  Description : Scoreboard bench for alu_cmd_seq: expected results are queued
//                at command acceptance and compared at result hand-off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_seq;

    typedef struct packed {
        logic [3:0] r;
        logic       f;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_select;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_flag;
    logic       out_zero;
    logic [7:0] op_count;

    int   checks  = 0;
    int   errors  = 0;
    int   exp_ops = 0;
    exp_t sb[$];

    alu_cmd_seq #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_select  (in_select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .out_zero   (out_zero),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Reference model of one command
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        exp_t       e;
        logic [4:0] wide;
        e = '0;
        case (s)
            3'd0: begin wide = 5'(a) + 5'(b); e.r = wide[3:0]; e.f = wide[4]; end
            3'd1: begin e.r = 4'((5'(a) + 5'd16 - 5'(b)) % 16); e.f = (a < b); end
            3'd2: e.r = a & b;
            3'd3: e.r = a | b;
            3'd4: e.r = a ^ b;
            3'd5: e.r = 4'd15 - a;
            3'd6: begin e.r = a / 2; e.f = a[0]; end
            default: begin e.r = 4'((a * 2) % 16); e.f = a[3]; end
        endcase
        e.z = (e.r == 4'd0);
        return e;
    endfunction

    // Offer one command, wait for acceptance, enqueue its expected result
    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int t;
        in_valid = 1'b1; in_a = a; in_b = b; in_select = s;
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 100);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            sb.push_back(model(a, b, s));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        exp_ops = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd1; in_select = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_result, out_flag, out_zero, op_count} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b vld=%0b res=%0h flg=%0b zero=%0b cnt=%0d required 1 0 0 0 0 0",
                     in_ready, out_valid, out_result, out_flag, out_zero, op_count);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_single_add();
        exp_t e;
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5; in_select = 3'd0;
        sb.push_back(model(4'd3, 4'd5, 3'd0));
        @(posedge clk); #1;                      // edge N: accepted
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_n: out_valid=%0b required 0", out_valid); end
        @(posedge clk); #1;                      // edge N+1
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_latency_n1: out_valid=%0b required 0", out_valid); end
        @(posedge clk); #1;                      // edge N+2
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency_n2: out_valid=%0b required 1", out_valid); end
        e = sb.pop_front();
        checks++;
        if ({out_result, out_flag, out_zero} !== {e.r, e.f, e.z} || out_result !== 4'b1000) begin
            errors++;
            $display("FAIL add_result: got %b/%0b/%0b required %b/%0b/%0b", out_result, out_flag, out_zero, e.r, e.f, e.z);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_ops++;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 8'(exp_ops)) begin
            errors++;
            $display("FAIL add_consume: out_valid=%0b op_count=%0d required 0 and %0d", out_valid, op_count, exp_ops);
        end
    endtask

    task automatic test_carry_borrow();
        exp_t e;
        int   t;
        out_ready = 1'b1;
        fork
            begin
                push_cmd(4'd9, 4'd8, 3'd0);
                push_cmd(4'd2, 4'd5, 3'd1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    t = 0;
                    do begin @(negedge clk); t++; end while (!(out_valid && out_ready) && t < 100);
                    checks++;
                    if (!(out_valid && out_ready) || sb.size() == 0) begin
                        errors++;
                        $display("FAIL carry_borrow_%0d: no result, out_valid=%0b pending=%0d", k, out_valid, sb.size());
                    end else begin
                        e = sb.pop_front();
                        exp_ops++;
                        if ({out_result, out_flag, out_zero} !== {e.r, e.f, e.z}) begin
                            errors++;
                            $display("FAIL carry_borrow_%0d: got %b/%0b/%0b required %b/%0b/%0b",
                                     k, out_result, out_flag, out_zero, e.r, e.f, e.z);
                        end
                    end
                end
            end
        join
        @(posedge clk); #1;
    endtask

    task automatic test_all_ops();
        exp_t e;
        int   t;
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                for (int s = 0; s < 8; s++) push_cmd(4'd5, 4'd2, 3'(s));
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    t = 0;
                    do begin @(negedge clk); t++; end while (!(out_valid && out_ready) && t < 100);
                    checks++;
                    if (!(out_valid && out_ready) || sb.size() == 0) begin
                        errors++;
                        $display("FAIL all_ops_%0d: no result, out_valid=%0b pending=%0d", k, out_valid, sb.size());
                    end else begin
                        e = sb.pop_front();
                        exp_ops++;
                        if ({out_result, out_flag, out_zero} !== {e.r, e.f, e.z}) begin
                            errors++;
                            $display("FAIL all_ops_%0d: got %b/%0b/%0b required %b/%0b/%0b",
                                     k, out_result, out_flag, out_zero, e.r, e.f, e.z);
                        end
                    end
                end
            end
        join
        @(posedge clk); #1;
        checks++;
        if (op_count !== 8'd8) begin
            errors++;
            $display("FAIL all_ops_count: op_count=%0d required 8", op_count);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   t;
        out_ready = 1'b0;
        push_cmd(4'd1, 4'd1, 3'd0);
        push_cmd(4'd7, 4'd3, 3'd1);
        push_cmd(4'd12, 4'd10, 3'd2);
        push_cmd(4'd8, 4'd0, 3'd7);
        push_cmd(4'd3, 4'd9, 3'd4);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%0b required 0", in_ready); end
        // Offer an extra command while full: it must be ignored
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_select = 3'd0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            e = sb[0];
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_result, out_flag, out_zero} !== {e.r, e.f, e.z}) begin
                errors++;
                $display("FAIL bp_hold_%0d: vld=%0b rdy=%0b res=%b/%0b/%0b required 1 0 %b/%0b/%0b",
                         c, out_valid, in_ready, out_result, out_flag, out_zero, e.r, e.f, e.z);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!(out_valid && out_ready) && t < 100);
            checks++;
            if (!(out_valid && out_ready) || sb.size() == 0) begin
                errors++;
                $display("FAIL bp_drain_%0d: no result, out_valid=%0b pending=%0d", k, out_valid, sb.size());
            end else begin
                e = sb.pop_front();
                exp_ops++;
                if ({out_result, out_flag, out_zero} !== {e.r, e.f, e.z}) begin
                    errors++;
                    $display("FAIL bp_drain_%0d: got %b/%0b/%0b required %b/%0b/%0b",
                             k, out_result, out_flag, out_zero, e.r, e.f, e.z);
                end
            end
        end
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_count !== 8'(exp_ops)) begin
            errors++;
            $display("FAIL bp_no_extra: out_valid=%0b op_count=%0d required 0 and %0d", out_valid, op_count, exp_ops);
        end
    endtask

    task automatic test_zero();
        exp_t e;
        int   t;
        out_ready = 1'b1;
        push_cmd(4'd5, 4'd5, 3'd1);
        t = 0;
        do begin @(negedge clk); t++; end while (!(out_valid && out_ready) && t < 100);
        checks++;
        if (!(out_valid && out_ready) || sb.size() == 0) begin
            errors++;
            $display("FAIL zero: no result, out_valid=%0b", out_valid);
        end else begin
            e = sb.pop_front();
            exp_ops++;
            if ({out_result, out_flag, out_zero} !== {e.r, e.f, e.z} || out_zero !== 1'b1) begin
                errors++;
                $display("FAIL zero: got %b/%0b/%0b required %b/%0b/%0b", out_result, out_flag, out_zero, e.r, e.f, e.z);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   t;
        int   seen;
        out_ready = 1'b0;
        push_cmd(4'd2, 4'd3, 3'd0);
        push_cmd(4'd4, 4'd1, 3'd1);
        push_cmd(4'd6, 4'd6, 3'd3);
        push_cmd(4'd9, 4'd9, 3'd4);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre: out_valid=%0b required 1", out_valid); end
        rst = 1'b1;
        in_valid = 1'b1; in_a = 4'd11; in_b = 4'd4; in_select = 3'd2;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        exp_ops = 0;
        checks++;
        if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL rmid_state: vld=%0b rdy=%0b cnt=%0d required 0 1 0", out_valid, in_ready, op_count);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rmid_stale: stale results=%0d required 0", seen); end
        @(posedge clk); #1;
        push_cmd(4'd1, 4'd1, 3'd0);
        t = 0;
        do begin @(negedge clk); t++; end while (!(out_valid && out_ready) && t < 100);
        checks++;
        if (!(out_valid && out_ready) || sb.size() == 0) begin
            errors++;
            $display("FAIL rmid_fresh: no result, out_valid=%0b", out_valid);
        end else begin
            e = sb.pop_front();
            exp_ops++;
            if ({out_result, out_flag, out_zero} !== {e.r, e.f, e.z}) begin
                errors++;
                $display("FAIL rmid_fresh: got %b/%0b/%0b required %b/%0b/%0b", out_result, out_flag, out_zero, e.r, e.f, e.z);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (op_count !== 8'(exp_ops)) begin
            errors++;
            $display("FAIL rmid_count: op_count=%0d required %0d", op_count, exp_ops);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_select = '0; out_ready = 1'b0;
        test_reset();
        test_single_add();
        test_carry_borrow();
        test_all_ops();
        test_backpressure();
        test_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  command FIFO can accept; equals !full from registered count.
REQ-006 SHALL have port in_a  input  4  operand a.
REQ-007 SHALL have port in_b  input  4  operand b.
REQ-008 SHALL have port in_select  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a, 110 a>>1, 111 a<<1.
REQ-009 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_result  output  4  ALU result.
REQ-012 SHALL have port out_flag  output  1  carry (add), borrow (sub), bit shifted out (shifts), else 0.
REQ-013 SHALL have port out_zero  output  1  out_result == 0.
REQ-014 SHALL have port op_count  output  8  results consumed since reset, wraps 255->0.

Function
REQ-015 SHALL write {in_a,in_b,in_select} into the FIFO tail on an edge where in_valid && in_ready.
REQ-016 SHALL use FSM states IDLE, EXEC, DONE.
REQ-017 IDLE: if FIFO non-empty, pop head into operand registers, go EXEC; else stay.
REQ-018 EXEC: drive the operand registers into the ALU, capture result/flag/zero into output registers, set out_valid, go DONE.
REQ-019 DONE: hold outputs stable while out_ready=0; on out_ready=1 clear out_valid, increment op_count, and pop the next head into EXEC if non-empty, else go IDLE.
REQ-020 Latency SHALL be: command accepted at edge N into an empty idle block -> out_valid high after edge N+2; sustained throughput one result per 2 cycles.
REQ-021 Arithmetic SHALL be 4-bit modulo: add flag = bit4 of a+b; sub result = (a-b) mod 16, flag = (a<b); shr logical (MSB fill 0), flag = a[0]; shl flag = a[3], LSB fill 0.
REQ-022 Full FIFO: in_ready=0, in_valid ignored, no entry overwritten.
REQ-023 Simultaneous push and pop on non-full FIFO: both take effect, count unchanged, order preserved.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; results SHALL emerge in acceptance order.
REQ-025 out_result/out_flag/out_zero SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-026 rst=1 at an edge SHALL: state IDLE, FIFO empty (in_ready=1), out_valid=0, out_result=0, out_flag=0, out_zero=0, op_count=0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight commands; no result from before reset appears afterwards.
REQ-028 in_valid asserted during rst SHALL not be accepted.

Structure
REQ-029 Opcode encodings, FSM state encoding and default FIFO_DEPTH SHALL live in shared package alu_pkg.
REQ-030 Result computation SHALL instantiate existing sub-module alu_4b (ports a, b, select, result); flags computed locally.
REQ-031 FIFO SHALL be inline register array with read/write pointers and count.

Verification
REQ-032 Single add: push a=3,b=5,sel=000 at edge N -> out_valid after N+2, result 1000, flag 0, zero 0.
REQ-033 Carry/borrow: push 9+8 then 2-5 -> results 0001 flag 1, then 1101 flag 1; order preserved.
REQ-034 All 8 ops on a=5,b=2 pushed back-to-back, out_ready=1 -> 0111,0011,0000,0111,0111,1010,0010(flag 1),1010(flag 0); op_count=8.
REQ-035 Backpressure: out_ready=0 while pushing 5 commands -> in_ready drops after 4th FIFO entry held; result stable; release drains all in order.
REQ-036 Zero: push a=5,b=5,sel=001 -> result 0000, out_zero 1, flag 0.
REQ-037 Reset with 3 queued and one in DONE -> next cycle out_valid 0, in_ready 1, op_count 0, no stale result after release.
